// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared types and helpers for the host I/O arbiter
package bp_me_pkg;

  typedef enum logic [1:0] {e_run, e_drain, e_idle} bp_host_arb_state_e;

  // Index width that stays legal when only one item exists
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_host_io_arbiter_id_fifo.sv
// rtl/bp_host_io_arbiter_id_fifo.sv - in-order FIFO of requester IDs for commands in flight
module bp_host_io_arbiter_id_fifo
  import bp_me_pkg::*;
#(
  parameter int depth_p = 16,
  parameter int width_p = 1
) (
  input  logic                       clk_i,
  input  logic                       reset_n_i,
  input  logic                       push_i,
  input  logic [width_p-1:0]         data_i,
  input  logic                       pop_i,
  output logic [width_p-1:0]         head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(depth_p):0]   count_o
);

  localparam int aw_lp = safe_clog2(depth_p);

  logic [width_p-1:0] mem_r [depth_p];
  logic [aw_lp:0]     wptr_r;
  logic [aw_lp:0]     rptr_r;

  // Extra wrap bit distinguishes full from empty when the indices match
  assign empty_o = (wptr_r == rptr_r);
  assign full_o  = (wptr_r[aw_lp] != rptr_r[aw_lp]) &&
                   (wptr_r[aw_lp-1:0] == rptr_r[aw_lp-1:0]);
  assign count_o = wptr_r - rptr_r;
  assign head_o  = mem_r[rptr_r[aw_lp-1:0]];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
    end else begin
      if (push_i) wptr_r <= wptr_r + 1'b1;
      if (pop_i)  rptr_r <= rptr_r + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) mem_r[wptr_r[aw_lp-1:0]] <= data_i;
  end

  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(push_i && full_o));
  assert property (@(posedge clk_i) disable iff (!reset_n_i) !(pop_i && empty_o));

endmodule

// File: rtl/bp_host_io_arbiter.sv
// rtl/bp_host_io_arbiter.sv - round-robin host I/O command arbiter with in-order response routing
// Optional trace (cycle counter and grant/resp/error prints) under BP_HOST_ARB_TRACE_EN.
module bp_host_io_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_req_p         = 2,
  parameter int msg_width_p       = 128,
  parameter int max_outstanding_p = 16,
  parameter int req_credits_p     = 4
) (
  input  logic                             clk_i,
  input  logic                             reset_n_i,
  input  logic [num_req_p*msg_width_p-1:0] cmd_i,
  input  logic [num_req_p-1:0]             cmd_v_i,
  output logic [num_req_p-1:0]             cmd_ready_and_o,
  output logic [msg_width_p-1:0]           io_cmd_o,
  output logic                             io_cmd_v_o,
  input  logic                             io_cmd_ready_and_i,
  input  logic [msg_width_p-1:0]           io_resp_i,
  input  logic                             io_resp_v_i,
  output logic                             io_resp_yumi_o,
  output logic [msg_width_p-1:0]           resp_o,
  output logic [num_req_p-1:0]             resp_v_o,
  input  logic [num_req_p-1:0]             resp_yumi_i,
  input  logic                             flush_i,
  output logic                             idle_o,
  output logic                             error_o
);

  localparam int id_width_lp   = safe_clog2(num_req_p);
  localparam int cred_width_lp = $clog2(req_credits_p + 1);
  localparam int cnt_width_lp  = $clog2(max_outstanding_p) + 1;

  bp_host_arb_state_e state_r, state_n;

  logic [id_width_lp-1:0]   rr_ptr_r;
  logic [id_width_lp-1:0]   grant;
  logic [id_width_lp-1:0]   cand;
  logic [id_width_lp-1:0]   head_id;
  logic [cred_width_lp-1:0] credit_r [num_req_p];
  logic [num_req_p-1:0]     eligible;
  logic [num_req_p-1:0]     credit_inc;
  logic [num_req_p-1:0]     credit_dec;
  logic [cnt_width_lp-1:0]  fifo_count;
  logic any_eligible, grant_en, cmd_hs, resp_pop, resp_drop;
  logic fifo_full, fifo_empty, error_r;

  function automatic int wrap_idx(input int i);
    return (i >= num_req_p) ? i - num_req_p : i;
  endfunction

  always_comb begin
    for (int i = 0; i < num_req_p; i++) begin
      eligible[i]   = cmd_v_i[i] & (credit_r[i] < cred_width_lp'(req_credits_p));
      credit_inc[i] = cmd_hs   & (grant   == id_width_lp'(i));
      credit_dec[i] = resp_pop & (head_id == id_width_lp'(i));
    end
  end

  // Scan from the farthest slot back so the one nearest the pointer wins
  always_comb begin
    grant        = '0;
    cand         = '0;
    any_eligible = 1'b0;
    for (int k = num_req_p - 1; k >= 0; k--) begin
      cand = id_width_lp'(wrap_idx(int'(rr_ptr_r) + k));
      if (eligible[cand]) begin
        grant        = cand;
        any_eligible = 1'b1;
      end
    end
  end

  always_comb begin
    io_cmd_o = '0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant == id_width_lp'(i)) io_cmd_o = cmd_i[i*msg_width_p +: msg_width_p];
    end
  end

  assign io_cmd_v_o      = reset_n_i & grant_en & any_eligible & ~fifo_full;
  assign cmd_hs          = io_cmd_v_o & io_cmd_ready_and_i;
  assign cmd_ready_and_o = cmd_hs ? (num_req_p'(1) << grant) : '0;

  assign resp_o         = io_resp_i;
  assign resp_v_o       = (reset_n_i & io_resp_v_i & ~fifo_empty) ? (num_req_p'(1) << head_id) : '0;
  assign resp_pop       = |(resp_v_o & resp_yumi_i);
  // A response with nothing outstanding is swallowed so the host never stalls on it
  assign resp_drop      = reset_n_i & io_resp_v_i & fifo_empty;
  assign io_resp_yumi_o = resp_pop | resp_drop;
  assign error_o        = error_r;

  bp_host_io_arbiter_id_fifo #(
    .depth_p (max_outstanding_p),
    .width_p (id_width_lp)
  ) id_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push_i    (cmd_hs),
    .data_i    (grant),
    .pop_i     (resp_pop),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  // Drain finishes as the last response pops, so idle_o rises the following cycle
  always_comb begin
    state_n  = state_r;
    grant_en = 1'b0;
    idle_o   = 1'b0;
    unique case (state_r)
      e_run: begin
        grant_en = 1'b1;
        if (flush_i) state_n = e_drain;
      end
      e_drain: begin
        if (!flush_i) state_n = e_run;
        else if (fifo_empty | (resp_pop & (fifo_count == cnt_width_lp'(1)))) state_n = e_idle;
      end
      e_idle: begin
        idle_o = 1'b1;
        if (!flush_i) state_n = e_run;
      end
      default: state_n = e_run;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= e_run;
      rr_ptr_r <= '0;
      error_r  <= 1'b0;
      for (int i = 0; i < num_req_p; i++) credit_r[i] <= '0;
    end else begin
      state_r <= state_n;
      if (cmd_hs) rr_ptr_r <= (grant == id_width_lp'(num_req_p - 1)) ? '0 : grant + 1'b1;
      if (resp_drop) error_r <= 1'b1;
      for (int i = 0; i < num_req_p; i++) begin
        if (credit_inc[i] & ~credit_dec[i])      credit_r[i] <= credit_r[i] + 1'b1;
        else if (credit_dec[i] & ~credit_inc[i]) credit_r[i] <= credit_r[i] - 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_credit_chk
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(credit_inc[gi] && !credit_dec[gi] && credit_r[gi] == cred_width_lp'(req_credits_p)));
    assert property (@(posedge clk_i) disable iff (!reset_n_i)
      !(credit_dec[gi] && !credit_inc[gi] && credit_r[gi] == '0));
  end

`ifdef BP_HOST_ARB_TRACE_EN
  logic [63:0] cyc_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cyc_r <= '0;
    end else begin
      cyc_r <= cyc_r + 64'd1;
      if (cmd_hs)               $display("[ARB] %0d grant=%0d", cyc_r, grant);
      if (resp_pop)             $display("[ARB] %0d resp=%0d", cyc_r, head_id);
      if (resp_drop & ~error_r) $display("[ARB] %0d error", cyc_r);
    end
  end
`endif

endmodule

// File: tb/tb_bp_host_io_arbiter.sv
// tb/tb_bp_host_io_arbiter.sv - randomized scoreboard bench for bp_host_io_arbiter
module tb_bp_host_io_arbiter;

  localparam int N = 5;
  localparam int W = 128;
  localparam int D = 16;
  localparam int C = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [N*W-1:0] cmd;
  logic [N-1:0]   cmd_v, cmd_ready;
  logic [W-1:0]   io_cmd;
  logic           io_cmd_v, io_cmd_ready;
  logic [W-1:0]   io_resp;
  logic           io_resp_v, io_resp_yumi;
  logic [W-1:0]   resp;
  logic [N-1:0]   resp_v, resp_yumi;
  logic           flush, idle, error;

  always #5 clk = ~clk;

  bp_host_io_arbiter #(
    .num_req_p(N), .msg_width_p(W), .max_outstanding_p(D), .req_credits_p(C)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n),
    .cmd_i(cmd), .cmd_v_i(cmd_v), .cmd_ready_and_o(cmd_ready),
    .io_cmd_o(io_cmd), .io_cmd_v_o(io_cmd_v), .io_cmd_ready_and_i(io_cmd_ready),
    .io_resp_i(io_resp), .io_resp_v_i(io_resp_v), .io_resp_yumi_o(io_resp_yumi),
    .resp_o(resp), .resp_v_o(resp_v), .resp_yumi_i(resp_yumi),
    .flush_i(flush), .idle_o(idle), .error_o(error)
  );

  typedef struct { int id; logic [W-1:0] data; } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] host_q[$];
  int           id_q[$];
  int           credit[N];
  int           rr;
  int           mstate;
  bit           merr;

  int p_cmd[N];
  int p_ready, p_resp, p_yumi;
  bit flush_k, force_empty;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] host_f(input logic [W-1:0] c);
    return {c[W/2-1:0], c[W-1:W/2]} ^ {16{8'hA5}};
  endfunction

  function automatic logic [W-1:0] rnd_msg();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic knobs(input int c, input int r, input int s, input int y);
    for (int i = 0; i < N; i++) p_cmd[i] = c;
    p_ready = r;
    p_resp  = s;
    p_yumi  = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    cmd_v = '1; io_cmd_ready = 1'b1; io_resp_v = 1'b0; resp_yumi = '1; flush = 1'b0;
    #1;
    check("rst_io_cmd_v", io_cmd_v, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_resp_v", resp_v, 0);
    check("rst_io_resp_yumi", io_resp_yumi, 0);
    check("rst_idle", idle, 0);
    check("rst_error", error, 0);
    rr = 0; mstate = 0; merr = 1'b0;
    for (int i = 0; i < N; i++) credit[i] = 0;
    id_q.delete(); host_q.delete(); exp_q.delete();
    @(negedge clk);
    cmd_v = '0; io_resp_v = 1'b0; reset_n = 1'b1;
  endtask

  task automatic cycle();
    logic [W-1:0] cdat [N];
    logic [N-1:0] exp_ready, exp_resp_v;
    bit exp_v, pop, drop;
    int g;
    exp_t e;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      cmd_v[i]     = ($urandom_range(99) < p_cmd[i]);
      cdat[i]      = rnd_msg();
      cmd[i*W +: W] = cdat[i];
      resp_yumi[i] = ($urandom_range(99) < p_yumi);
    end
    io_cmd_ready = ($urandom_range(99) < p_ready);
    if (force_empty && host_q.size() == 0) begin
      io_resp_v = 1'b1; io_resp = rnd_msg();
    end else if (host_q.size() > 0 && $urandom_range(99) < p_resp) begin
      io_resp_v = 1'b1; io_resp = host_f(host_q[0]);
    end else begin
      io_resp_v = 1'b0; io_resp = rnd_msg();
    end
    flush = flush_k;
    #1;
    exp_v = 1'b0; g = 0;
    if (mstate == 0 && id_q.size() < D) begin
      for (int k = 0; k < N; k++) begin
        int r;
        r = (rr + k) % N;
        if (!exp_v && cmd_v[r] && credit[r] < C) begin
          exp_v = 1'b1; g = r;
        end
      end
    end
    check("io_cmd_v", io_cmd_v, exp_v);
    if (exp_v) check("io_cmd", io_cmd, cdat[g]);
    exp_ready = (exp_v && io_cmd_ready) ? (N'(1) << g) : '0;
    check("cmd_ready", cmd_ready, exp_ready);
    exp_resp_v = (io_resp_v && id_q.size() > 0) ? (N'(1) << id_q[0]) : '0;
    check("resp_v", resp_v, exp_resp_v);
    pop  = io_resp_v && id_q.size() > 0 && resp_yumi[id_q[0]];
    drop = io_resp_v && id_q.size() == 0;
    check("io_resp_yumi", io_resp_yumi, pop || drop);
    check("idle", idle, mstate == 2);
    check("error", error, merr);
    if (exp_v && io_cmd_ready) begin
      id_q.push_back(g);
      credit[g]++;
      rr = (g + 1) % N;
      host_q.push_back(cdat[g]);
      e.id = g; e.data = host_f(cdat[g]);
      exp_q.push_back(e);
    end
    if (pop) begin
      credit[id_q[0]]--;
      void'(id_q.pop_front());
      void'(host_q.pop_front());
    end
    if (drop) merr = 1'b1;
    case (mstate)
      0: if (flush) mstate = 1;
      1: if (!flush) mstate = 0; else if (id_q.size() == 0) mstate = 2;
      default: if (!flush) mstate = 0;
    endcase
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (reset_n && |(resp_v & resp_yumi)) begin
        if (exp_q.size() == 0) begin
          check("resp_unexpected", resp_v, 0);
        end else begin
          e = exp_q.pop_front();
          check("resp_route", resp_v, N'(1) << e.id);
          check("resp_data", resp, e.data);
        end
      end
    end
  end

  initial begin
    cmd = '0; cmd_v = '0; io_cmd_ready = 1'b0; io_resp = '0; io_resp_v = 1'b0;
    resp_yumi = '0; flush = 1'b0; flush_k = 1'b0; force_empty = 1'b0;
    knobs(0, 0, 0, 0);
    do_reset();

    knobs(100, 100, 100, 100);
    repeat (12) cycle();

    knobs(0, 100, 0, 0);
    p_cmd[0] = 100;
    repeat (6) cycle();
    p_cmd[1] = 100;
    repeat (3) cycle();
    knobs(0, 100, 100, 100);
    repeat (30) cycle();

    knobs(100, 100, 0, 0);
    repeat (24) cycle();
    knobs(100, 100, 100, 100);
    repeat (4) cycle();
    knobs(0, 100, 100, 100);
    repeat (30) cycle();

    force_empty = 1'b1;
    cycle();
    force_empty = 1'b0;
    knobs(60, 70, 60, 70);
    repeat (20) cycle();
    do_reset();

    knobs(0, 100, 0, 0);
    p_cmd[0] = 100;
    repeat (3) cycle();
    flush_k = 1'b1;
    knobs(100, 100, 100, 100);
    repeat (8) cycle();
    flush_k = 1'b0;
    repeat (6) cycle();

    for (int s = 0; s < 60; s++) begin
      for (int i = 0; i < N; i++) p_cmd[i] = $urandom_range(100);
      p_ready = 20 + $urandom_range(80);
      p_resp  = $urandom_range(100);
      p_yumi  = 20 + $urandom_range(80);
      flush_k = ($urandom_range(99) < 20);
      repeat (50) cycle();
    end

    flush_k = 1'b0;
    knobs(0, 100, 100, 100);
    repeat (40) cycle();
    @(negedge clk);
    #3;
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
